// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and flag layout for the sequential ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int F_ZERO  = 1;
    localparam int F_CARRY = 0;

    function automatic logic [1:0] make_flags(input logic zero, input logic carry);
        make_flags          = 2'b00;
        make_flags[F_ZERO]  = zero;
        make_flags[F_CARRY] = carry;
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned multiplier, one shift-add step per cycle, LSB of b first.
// done is asserted on the cycle of the final step; product is that step's sum, valid with done.
module shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic                 busy;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   next_acc;

    // The last step is summed combinationally so the caller can register it on the same edge.
    assign next_acc = acc + (mplier[0] ? mcand : '0);
    assign product  = next_acc;
    assign done     = busy && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (busy) begin
            acc <= next_acc;
            if (done) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt    <= cnt + CW'(1);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: non-MUL results 1 edge after accept, MUL after WIDTH edges.
// Result held stable under out_ready=0; a new op is accepted in DONE only alongside the output transfer.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   rslt,
    output logic [1:0]           flags
);

    import alu_pkg::*;

    logic [1:0]           state;
    logic                 accept;
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   alu_res;
    logic                 alu_carry;

    assign in_ready  = (state == S_IDLE) || (state == S_DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (opcode == OP_MUL);

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res   = {{(WIDTH-1){1'b0}}, sum};
                alu_carry = sum[WIDTH];
            end
            // diff[WIDTH] doubles as the sign of the difference and the borrow
            OP_SUB: begin
                alu_res   = {{(WIDTH-1){diff[WIDTH]}}, diff};
                alu_carry = diff[WIDTH];
            end
            OP_AND:  alu_res = {{WIDTH{1'b0}}, a & b};
            OP_OR:   alu_res = {{WIDTH{1'b0}}, a | b};
            OP_NOT:  alu_res = {{WIDTH{1'b0}}, ~a};
            OP_XOR:  alu_res = {{WIDTH{1'b0}}, a ^ b};
            OP_XNOR: alu_res = {{WIDTH{1'b0}}, ~(a ^ b)};
            default: alu_res = '0;
        endcase
    end

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            rslt      <= '0;
            flags     <= 2'b00;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (opcode == OP_MUL) begin
                            state     <= S_MUL;
                            out_valid <= 1'b0;
                        end else begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            rslt      <= alu_res;
                            flags     <= make_flags(alu_res == '0, alu_carry);
                        end
                    end else if (state == S_DONE && out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                S_MUL: begin
                    if (mul_done) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        rslt      <= mul_product;
                        flags     <= make_flags(mul_product == '0, 1'b0);
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
